// File: rtl/text_pixel_reader.sv
// text_pixel_reader: renders a ROWS x COLS character buffer as a raster pixel stream via a font ROM.
// Latency: 4 cycles per character cell (char fetch/wait, font fetch/wait) before its 8 pixels are offered.
// Backpressure: pix_ready low while pix_valid holds pix_data/pix_sol/pix_eof and every counter.
//
// Ports:
//   clk, reset (async, active-low), start (sampled in IDLE only), busy
//   char_rd_en/char_rd_addr/char_rd_data : character memory, data one cycle after the strobe
//   font_rd_en/font_addr/font_data       : font ROM, {code, glyph_line}, bit 7 = leftmost pixel
//   pix_valid/pix_ready/pix_data         : pixel stream, FG for glyph bit 1, BG for 0
//   pix_sol, pix_eof                     : first pixel of scanline / last pixel of frame
//   frame_done                           : one-cycle pulse after the pix_eof beat is accepted
module text_pixel_reader #(
  parameter int          COLS   = 64,
  parameter int          ROWS   = 20,
  parameter int          CHAR_H = 8,
  parameter logic [7:0]  FG     = 8'hFF,
  parameter logic [7:0]  BG     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        char_rd_en,
  output logic [15:0] char_rd_addr,
  input  logic [7:0]  char_rd_data,
  output logic        font_rd_en,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        pix_sol,
  output logic        pix_eof,
  output logic        frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [2:0]    LINE_LAST = 3'(CHAR_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_CHAR,
    S_WAIT_CHAR,
    S_FETCH_FONT,
    S_WAIT_FONT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    glyph_line;
  logic [2:0]    bit_idx;
  logic [7:0]    char_reg;
  logic [7:0]    shift_reg;

  logic col_last, row_last, line_last, bit_last, frame_last;

  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  assign line_last  = (glyph_line == LINE_LAST);
  assign bit_last   = (bit_idx == 3'd0);
  assign frame_last = row_last && line_last && col_last;

  // Addresses follow the counters directly; counters are zero in reset so both read 0 there.
  assign char_rd_addr = 16'(row) * 16'(COLS) + 16'(col);
  assign font_addr    = {char_reg, glyph_line};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      glyph_line <= '0;
      bit_idx    <= '0;
      char_reg   <= '0;
      shift_reg  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            col        <= '0;
            row        <= '0;
            glyph_line <= '0;
            bit_idx    <= '0;
          end
        end
        S_WAIT_CHAR: char_reg <= char_rd_data;
        S_WAIT_FONT: begin
          shift_reg <= font_data;
          bit_idx   <= 3'd7;
        end
        S_SHIFT: begin
          if (pix_ready) begin
            bit_idx <= bit_idx - 3'd1;
            // Cell finished: step col, carrying into glyph_line then row.
            // No line buffer, so a text row is walked again for each of its scanlines.
            if (bit_last) begin
              if (!col_last) begin
                col <= col + CW'(1);
              end else begin
                col <= '0;
                if (!line_last) begin
                  glyph_line <= glyph_line + 3'd1;
                end else begin
                  glyph_line <= '0;
                  row        <= row_last ? '0 : row + RW'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    char_rd_en = 1'b0;
    font_rd_en = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = 8'h00;
    pix_sol    = 1'b0;
    pix_eof    = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH_CHAR;
      end
      S_FETCH_CHAR: begin
        char_rd_en = 1'b1;
        state_nxt  = S_WAIT_CHAR;
      end
      S_WAIT_CHAR: state_nxt = S_FETCH_FONT;
      S_FETCH_FONT: begin
        font_rd_en = 1'b1;
        state_nxt  = S_WAIT_FONT;
      end
      S_WAIT_FONT: state_nxt = S_SHIFT;
      S_SHIFT: begin
        pix_valid = 1'b1;
        pix_data  = shift_reg[bit_idx] ? FG : BG;
        pix_sol   = (col == '0) && (bit_idx == 3'd7);
        pix_eof   = frame_last && bit_last;
        if (pix_ready && bit_last) begin
          state_nxt = frame_last ? S_DONE : S_FETCH_CHAR;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_pixel_reader.sv
module tb_text_pixel_reader;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int CHAR_H = 8;
  localparam int NPIX   = ROWS * CHAR_H * COLS * 8;
  localparam int LIMIT  = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        char_rd_en;
  logic [15:0] char_rd_addr;
  logic [7:0]  char_rd_data;
  logic        font_rd_en;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_sol;
  logic        pix_eof;
  logic        frame_done;

  text_pixel_reader #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .FG(8'hFF), .BG(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .char_rd_en(char_rd_en), .char_rd_addr(char_rd_addr), .char_rd_data(char_rd_data),
    .font_rd_en(font_rd_en), .font_addr(font_addr), .font_data(font_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sol(pix_sol), .pix_eof(pix_eof), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       eof;
  } pix_t;

  logic [7:0]  char_mem [0:ROWS*COLS-1];
  logic [7:0]  font_mem [0:2047];
  pix_t        exp_q [$];
  logic [15:0] caddr_q [$];
  logic [10:0] faddr_q [$];

  int compared   = 0;
  int mismatched = 0;
  int acc_cnt, sol_cnt, eof_cnt, done_cnt;
  bit rand_mode = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memories with one-cycle read latency.
  always @(posedge clk) begin
    if (char_rd_en) char_rd_data <= (char_rd_addr < ROWS*COLS) ? char_mem[char_rd_addr] : 8'hxx;
    if (font_rd_en) font_data <= font_mem[font_addr];
  end

  always @(posedge clk) begin
    #1;
    pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference: whole frame as raster loops over text rows, scanlines, cells and glyph bits.
  task automatic build_expect();
    for (int r = 0; r < ROWS; r++)
      for (int g = 0; g < CHAR_H; g++)
        for (int c = 0; c < COLS; c++) begin
          logic [7:0] code;
          logic [7:0] bits;
          pix_t p;
          code = char_mem[r*COLS + c];
          caddr_q.push_back(16'(r*COLS + c));
          faddr_q.push_back({code, 3'(g)});
          bits = font_mem[{code, 3'(g)}];
          for (int b = 7; b >= 0; b--) begin
            p.d   = bits[b] ? 8'hFF : 8'h00;
            p.sol = (c == 0) && (b == 7);
            p.eof = (r == ROWS-1) && (g == CHAR_H-1) && (c == COLS-1) && (b == 0);
            exp_q.push_back(p);
          end
        end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or an accepted pixel.
  bit         prev_stall = 1'b0;
  bit         prev_eof_acc = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sol, prev_eof;

  always @(negedge clk) begin
    if (reset) begin
      if (char_rd_en && font_rd_en) check("strobe_overlap", 1, 0);
      if (char_rd_en) begin
        if (caddr_q.size() == 0) check("char_addr_unexpected", char_rd_addr, 16'hFFFF);
        else check("char_addr", char_rd_addr, caddr_q.pop_front());
      end
      if (font_rd_en) begin
        if (faddr_q.size() == 0) check("font_addr_unexpected", font_addr, 11'h7FF);
        else check("font_addr", font_addr, faddr_q.pop_front());
      end
      if (prev_stall)
        check("stall_hold", {pix_valid, pix_sol, pix_eof, pix_data},
              {1'b1, prev_sol, prev_eof, prev_data});
      if (frame_done) begin
        done_cnt++;
        check("done_after_eof", prev_eof_acc, 1);
      end
      if (pix_valid && pix_ready) begin
        acc_cnt++;
        if (pix_sol) sol_cnt++;
        if (pix_eof) eof_cnt++;
        if (exp_q.size() == 0) check("pix_unexpected", pix_data, 9'h100);
        else begin
          pix_t e;
          e = exp_q.pop_front();
          check("pix_data", pix_data, e.d);
          check("pix_sol_eof", {pix_sol, pix_eof}, {e.sol, e.eof});
        end
      end
      prev_stall   = pix_valid && !pix_ready;
      prev_eof_acc = pix_valid && pix_ready && pix_eof;
      prev_data    = pix_data;
      prev_sol     = pix_sol;
      prev_eof     = pix_eof;
    end else begin
      prev_stall   = 1'b0;
      prev_eof_acc = 1'b0;
    end
  end

  task automatic clear_counts();
    acc_cnt = 0; sol_cnt = 0; eof_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input bit chk_cell, input bit mid_start);
    logic [7:0] first8 [0:7];
    int n;
    first8 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_counts();
    build_expect();
    pulse_start();
    @(negedge clk);
    check("lat_char_rd_en", {char_rd_en, busy, pix_valid}, 3'b110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lat_no_pix", pix_valid, 0);
    end
    @(negedge clk);
    check("lat_first_pix", pix_valid, 1);
    if (chk_cell) begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) @(negedge clk);
        check("cell0_pix", pix_data, first8[i]);
      end
    end
    if (mid_start) begin
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!frame_done && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", {frame_done, busy}, 2'b11);
    @(negedge clk);
    check("busy_low_after_done", {busy, frame_done}, 2'b00);
    check("pix_count", acc_cnt, NPIX);
    check("sol_count", sol_cnt, ROWS*CHAR_H);
    check("eof_count", eof_cnt, 1);
    check("done_count", done_cnt, 1);
    check("queues_empty", exp_q.size() + caddr_q.size() + faddr_q.size(), 0);
    exp_q.delete(); caddr_q.delete(); faddr_q.delete();
  endtask

  task automatic reset_mid_frame();
    int n;
    clear_counts();
    build_expect();
    pulse_start();
    n = 0;
    while (!(acc_cnt >= 300 && pix_valid) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_shift", pix_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("midreset_ctrl", {busy, char_rd_en, font_rd_en, pix_valid, pix_sol, pix_eof, frame_done}, 0);
    check("midreset_data", {char_rd_addr, pix_data}, 0);
    exp_q.delete(); caddr_q.delete(); faddr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midreset_no_done", {frame_done, busy}, 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {busy, frame_done, pix_valid}, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < ROWS*COLS; i++) char_mem[i] = 8'($urandom_range(0, 255));
    char_mem[0] = 8'h41;
    font_mem[{8'h41, 3'd0}] = 8'hA0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, char_rd_en, font_rd_en, pix_valid, pix_sol, pix_eof, frame_done}, 0);
    check("rst_addr", {char_rd_addr, font_addr}, 0);
    check("rst_pix_data", pix_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Frame with a known first cell, sink always ready.
    rand_mode = 1'b0;
    run_frame(1'b1, 1'b0);

    // Character code equals its address.
    for (int i = 0; i < ROWS*COLS; i++) char_mem[i] = 8'(i);
    run_frame(1'b0, 1'b0);

    // Random characters with random backpressure.
    for (int i = 0; i < ROWS*COLS; i++) char_mem[i] = 8'($urandom_range(0, 255));
    rand_mode = 1'b1;
    run_frame(1'b0, 1'b0);

    // Abort mid-frame, then a fresh frame must restart at address 0.
    reset_mid_frame();
    rand_mode = 1'b0;
    run_frame(1'b0, 1'b1);

    // start pulsed while busy under backpressure.
    rand_mode = 1'b1;
    run_frame(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
